sb_rx_decoder: RTL and testbench
================================

# sb_rx_decoder

Sideband receive decoder for the USB4 logical layer. It sits between the electrical layer's `sbrx` line and the logical layer's LT/AT transaction handling. It recovers UART-framed sideband symbols (one bit per `sb_clk`) and removes DLE framing and stuffing. It delivers Link-Type (LT) events and Attribute-Transaction (AT) byte streams to the logical layer.

## Interface
Parameters:
- `DLE`, 8'hFE, framing escape symbol
- `STX`, 8'h05, AT start symbol (follows DLE)
- `ETX`, 8'h40, AT end symbol (follows DLE)
- `MAX_LEN`, 64, maximum de-stuffed AT payload bytes

Ports:
- `sb_clk`  in  1  sideband clock, one line bit per cycle; the only clock
- `rst`  in  1  **synchronous, active-high** reset
- `sbrx`  in  1  sideband receive line, idle high, asynchronous to `sb_clk`
- `enable`  in  1  receive enable
- `lt_valid`  out  1  one-cycle pulse: valid LT transaction received
- `lt_lse`  out  8  LSE symbol of the LT transaction, held until next `lt_valid`
- `at_valid`  out  1  one-cycle pulse: `at_data` valid
- `at_data`  out  8  de-stuffed AT byte
- `at_sop`  out  1  qualifies first byte of an AT (only with `at_valid`)
- `at_eop`  out  1  qualifies last byte of an AT (only with `at_valid`)
- `at_err`  out  1  one-cycle pulse: current AT aborted; consumer discards partial transaction
- `frame_err`  out  1  one-cycle pulse: stop-bit error or LT complement mismatch

## Operation
- **Synchroniser:** `sbrx` passes through a 2-flop synchroniser. Both flops reset to 1 so reset cannot create a false start.
- **Symbol receiver FSM, states RX_IDLE, RX_DATA, RX_STOP:**
  - RX_IDLE: a synchronised 0 moves to RX_DATA with the bit counter at 0.
  - RX_DATA: captures 8 bits LSB first over 8 cycles, counter 0..7, then moves to RX_STOP.
  - RX_STOP: a 1 asserts the internal `sym_valid` for one cycle. A 0 pulses `frame_err` and drops the symbol.
  - After RX_STOP the FSM always returns to RX_IDLE. A start bit in the next cycle is accepted, so back-to-back frames are 10 cycles each.
- **Parser FSM, states P_IDLE, P_DLE, P_LSE, P_AT, P_AT_DLE.** It advances only on `sym_valid`.
  - P_IDLE:
    - DLE → P_DLE.
    - Anything else is discarded.
  - P_DLE:
    - STX → P_AT; clear the length counter; set `first`.
    - DLE → stay in P_DLE.
    - ETX → P_IDLE.
    - Any other value → latch it as the LSE, go to P_LSE.
  - P_LSE:
    - Symbol == ~LSE → pulse `lt_valid` and update `lt_lse`.
    - Otherwise pulse `frame_err`.
    - Either way → P_IDLE.
  - P_AT:
    - DLE → P_AT_DLE.
    - Otherwise the symbol is a payload byte.
  - P_AT_DLE:
    - DLE → payload byte 8'hFE, then P_AT.
    - ETX → end of transaction.
    - Any other value → `at_err`, P_IDLE.
- **One-byte hold register:** each payload byte is held until the next payload byte or ETX arrives.
  - A new payload byte emits the held byte (`at_sop` = `first`; clear `first`).
  - ETX emits the held byte with `at_eop`=1 (and `at_sop` if it is also the first byte).
  - ETX with the hold register empty (zero-length AT) → `at_err` only; no data is emitted.
- **Length:** the counter increments per de-stuffed payload byte. The payload byte that would make the count `MAX_LEN`+1 is not stored; it triggers `at_err` and P_IDLE. Exactly `MAX_LEN` bytes is legal.
- **`enable` low:**
  - Both FSMs are forced to their idle states and the hold register is cleared.
  - If the parser was in P_AT or P_AT_DLE, `at_err` pulses once.
  - The synchroniser keeps running.
- **Reset:**
  - Synchroniser flops = 1.
  - FSMs idle; hold register cleared.
  - `lt_lse` = 0; all pulse and qualifier outputs = 0; `at_data` = 0.
  - Reset mid-transaction gives no `at_err`.
- **Simultaneous events:** `frame_err` and parser outputs are independent registers and may assert in the same cycle.

## Timing
- All outputs are registered on `sb_clk`.
- The stop bit reaches the synchroniser output at cycle N; RX_STOP samples it at N. `sym_valid` is at N+1, and parser outputs (`lt_valid`, `at_*`, LSE `frame_err`) are at N+2.
- Pin-to-synchroniser latency is 2 cycles.
- `at_valid` is at most one pulse per symbol, so there are at least 10 cycles between `at_valid` pulses.
- There is no backpressure; the consumer must accept every pulse.

## Test plan
- **LT:** frames DLE, 8'h23, 8'hDC → single `lt_valid`, `lt_lse`=8'h23, no `frame_err`. A second LT with CLSE 8'hDD → `frame_err` pulse, no `lt_valid`, `lt_lse` still 8'h23.
- **AT:** DLE STX 11 22 33 DLE ETX → three `at_valid` pulses with data 11/22/33. `at_sop` on 11, `at_eop` on 33, `at_err` never asserted; `at_eop` arrives 2 cycles after ETX's stop bit.
- **Stuffing and edge lengths:**
  - DLE STX DLE DLE 01 DLE ETX → bytes FE (sop), 01 (eop).
  - DLE STX DLE ETX → `at_err` only.
  - Single byte 7A → one pulse with `at_sop` and `at_eop` both set.
- **Framing:** stop bit driven 0 on the 2nd AT payload byte → `frame_err`, byte dropped, the rest of the AT is delivered normally. Back-to-back 10-cycle frames are all received.
- **Overflow:** DLE STX followed by 65 bytes of 8'hAA → 64 `at_valid` pulses, none with `at_eop`, then `at_err`. The trailing DLE ETX produces no output.
- **Reset/enable mid-AT:**
  - `rst` after 3 payload bytes → all outputs 0 the next cycle, no `at_err`; a following LT (LSE 8'h10) decodes correctly.
  - `enable` dropped mid-AT → exactly one `at_err` pulse.

Source files
------------

// File: rtl/sb_rx_decoder.sv
// Sideband receive decoder: recovers UART-framed symbols from sbrx, strips DLE
// framing/stuffing and delivers LT events and AT byte streams.
module sb_rx_decoder #(
    parameter logic [7:0]  DLE     = 8'hFE,
    parameter logic [7:0]  STX     = 8'h05,
    parameter logic [7:0]  ETX     = 8'h40,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       sbrx,
    input  logic       enable,
    output logic       lt_valid,
    output logic [7:0] lt_lse,
    output logic       at_valid,
    output logic [7:0] at_data,
    output logic       at_sop,
    output logic       at_eop,
    output logic       at_err,
    output logic       frame_err
);

    localparam int unsigned LenW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {RxIdle, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {PIdle, PDle, PLse, PAt, PAtDle} p_state_e;

    logic            sync1_q, sync2_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            sym_valid_q, sym_valid_d;
    logic            stop_err;
    logic [7:0]      sym;

    p_state_e        p_state_q, p_state_d;
    logic [7:0]      lse_q, lse_d;
    logic [LenW-1:0] len_q, len_d;
    logic            first_q, first_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_vld_q, hold_vld_d;
    logic            payload, lse_err;

    logic            lt_valid_q, lt_valid_d;
    logic [7:0]      lt_lse_q, lt_lse_d;
    logic            at_valid_q, at_valid_d;
    logic [7:0]      at_data_q, at_data_d;
    logic            at_sop_q, at_sop_d;
    logic            at_eop_q, at_eop_d;
    logic            at_err_q, at_err_d;
    logic            frame_err_q, frame_err_d;

    // The shift register is untouched while sym_valid_q is high (receiver is back in idle).
    assign sym = shift_q;

    // Two-flop synchroniser; resets to idle-high so reset cannot fake a start bit.
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sbrx;
            sync2_q <= sync1_q;
        end
    end

    // Symbol receiver next state: start bit, 8 data bits LSB first, stop bit.
    always_comb begin
        rx_state_d  = rx_state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sym_valid_d = 1'b0;
        stop_err    = 1'b0;
        if (!enable) begin
            rx_state_d = RxIdle;
        end else begin
            case (rx_state_q)
                RxIdle: begin
                    if (!sync2_q) begin
                        rx_state_d = RxData;
                        bit_cnt_d  = 3'd0;
                    end
                end
                RxData: begin
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end
                RxStop: begin
                    rx_state_d = RxIdle;
                    if (sync2_q) begin
                        sym_valid_d = 1'b1;
                    end else begin
                        stop_err = 1'b1;
                    end
                end
                default: rx_state_d = RxIdle;
            endcase
        end
    end

    // Symbol receiver state registers.
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            rx_state_q  <= RxIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            sym_valid_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sym_valid_q <= sym_valid_d;
        end
    end

    // Parser next state: DLE framing, LT check, AT de-stuffing with a one-byte hold.
    always_comb begin
        p_state_d   = p_state_q;
        lse_d       = lse_q;
        len_d       = len_q;
        first_d     = first_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        lt_valid_d  = 1'b0;
        lt_lse_d    = lt_lse_q;
        at_valid_d  = 1'b0;
        at_data_d   = at_data_q;
        at_sop_d    = 1'b0;
        at_eop_d    = 1'b0;
        at_err_d    = 1'b0;
        payload     = 1'b0;
        lse_err     = 1'b0;
        if (!enable) begin
            p_state_d  = PIdle;
            hold_vld_d = 1'b0;
            at_err_d   = (p_state_q == PAt) || (p_state_q == PAtDle);
        end else if (sym_valid_q) begin
            case (p_state_q)
                PIdle: begin
                    if (sym == DLE) p_state_d = PDle;
                end
                PDle: begin
                    if (sym == STX) begin
                        p_state_d  = PAt;
                        len_d      = '0;
                        first_d    = 1'b1;
                        hold_vld_d = 1'b0;
                    end else if (sym == ETX) begin
                        p_state_d = PIdle;
                    end else if (sym != DLE) begin
                        lse_d     = sym;
                        p_state_d = PLse;
                    end
                end
                PLse: begin
                    if (sym == ~lse_q) begin
                        lt_valid_d = 1'b1;
                        lt_lse_d   = lse_q;
                    end else begin
                        lse_err = 1'b1;
                    end
                    p_state_d = PIdle;
                end
                PAt: begin
                    if (sym == DLE) p_state_d = PAtDle;
                    else            payload   = 1'b1;
                end
                PAtDle: begin
                    if (sym == DLE) begin
                        payload   = 1'b1;
                        p_state_d = PAt;
                    end else begin
                        if (sym == ETX && hold_vld_q) begin
                            at_valid_d = 1'b1;
                            at_data_d  = hold_q;
                            at_sop_d   = first_q;
                            at_eop_d   = 1'b1;
                        end else begin
                            // Zero-length AT or illegal escape.
                            at_err_d = 1'b1;
                        end
                        hold_vld_d = 1'b0;
                        p_state_d  = PIdle;
                    end
                end
                default: p_state_d = PIdle;
            endcase

            if (payload) begin
                if (hold_vld_q) begin
                    at_valid_d = 1'b1;
                    at_data_d  = hold_q;
                    at_sop_d   = first_q;
                    first_d    = 1'b0;
                end
                if (len_q == LenW'(MAX_LEN)) begin
                    // Overlength byte is dropped and aborts the AT.
                    at_err_d   = 1'b1;
                    hold_vld_d = 1'b0;
                    p_state_d  = PIdle;
                end else begin
                    hold_d     = sym;
                    hold_vld_d = 1'b1;
                    len_d      = len_q + LenW'(1);
                end
            end
        end
        frame_err_d = stop_err | lse_err;
    end

    // Parser state and registered outputs.
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            p_state_q   <= PIdle;
            lse_q       <= 8'h00;
            len_q       <= '0;
            first_q     <= 1'b0;
            hold_q      <= 8'h00;
            hold_vld_q  <= 1'b0;
            lt_valid_q  <= 1'b0;
            lt_lse_q    <= 8'h00;
            at_valid_q  <= 1'b0;
            at_data_q   <= 8'h00;
            at_sop_q    <= 1'b0;
            at_eop_q    <= 1'b0;
            at_err_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            p_state_q   <= p_state_d;
            lse_q       <= lse_d;
            len_q       <= len_d;
            first_q     <= first_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            lt_valid_q  <= lt_valid_d;
            lt_lse_q    <= lt_lse_d;
            at_valid_q  <= at_valid_d;
            at_data_q   <= at_data_d;
            at_sop_q    <= at_sop_d;
            at_eop_q    <= at_eop_d;
            at_err_q    <= at_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign lt_valid  = lt_valid_q;
    assign lt_lse    = lt_lse_q;
    assign at_valid  = at_valid_q;
    assign at_data   = at_data_q;
    assign at_sop    = at_sop_q;
    assign at_eop    = at_eop_q;
    assign at_err    = at_err_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sb_rx_decoder.sv
// Scoreboard bench for sb_rx_decoder: the driver serialises directed symbol
// sequences and queues the expected events; a monitor pops and compares them.
module tb_sb_rx_decoder;

    logic       sb_clk = 1'b0;
    logic       rst;
    logic       sbrx;
    logic       enable;
    logic       lt_valid;
    logic [7:0] lt_lse;
    logic       at_valid;
    logic [7:0] at_data;
    logic       at_sop;
    logic       at_eop;
    logic       at_err;
    logic       frame_err;

    localparam logic [7:0] DLE = 8'hFE;
    localparam logic [7:0] STX = 8'h05;
    localparam logic [7:0] ETX = 8'h40;

    typedef enum logic [1:0] {EvLt, EvAt, EvAtErr, EvFrameErr} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  eop_cyc = -1;
    int  stop_cyc = 0;

    sb_rx_decoder dut (
        .sb_clk    (sb_clk),
        .rst       (rst),
        .sbrx      (sbrx),
        .enable    (enable),
        .lt_valid  (lt_valid),
        .lt_lse    (lt_lse),
        .at_valid  (at_valid),
        .at_data   (at_data),
        .at_sop    (at_sop),
        .at_eop    (at_eop),
        .at_err    (at_err),
        .frame_err (frame_err)
    );

    always #5 sb_clk = ~sb_clk;

    always @(posedge sb_clk) cyc <= cyc + 1;

    task automatic push(input ev_kind_e k, input logic [7:0] d, input logic s, input logic e);
        ev_t x;
        x.kind = k;
        x.data = d;
        x.sop  = s;
        x.eop  = e;
        exp_q.push_back(x);
    endtask

    task automatic check_ev(input ev_kind_e k, input logic [7:0] d, input logic s,
                            input logic e, input string nm);
        ev_t x;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: got unexpected event kind=%0d data=%02h sop=%0b eop=%0b, required none",
                     nm, k, d, s, e);
        end else begin
            x = exp_q.pop_front();
            if (x.kind != k || x.data !== d || x.sop !== s || x.eop !== e) begin
                fails++;
                $display("FAIL %s: got kind=%0d data=%02h sop=%0b eop=%0b, required kind=%0d data=%02h sop=%0b eop=%0b",
                         nm, k, d, s, e, x.kind, x.data, x.sop, x.eop);
            end
        end
    endtask

    // Monitor: one sample per cycle, 1 time unit after the active edge.
    always @(posedge sb_clk) begin
        #1;
        if (rst === 1'b0) begin
            if (lt_valid) check_ev(EvLt, lt_lse, 1'b0, 1'b0, "lt");
            if (at_valid) begin
                check_ev(EvAt, at_data, at_sop, at_eop, "at_byte");
                if (at_eop) eop_cyc = cyc;
            end
            if (at_err)    check_ev(EvAtErr, 8'h00, 1'b0, 1'b0, "at_err");
            if (frame_err) check_ev(EvFrameErr, 8'h00, 1'b0, 1'b0, "frame_err");
        end
    end

    task automatic send_bit(input logic b);
        @(negedge sb_clk);
        sbrx = b;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        // Edge at which the stop bit enters the synchroniser.
        stop_cyc = cyc + 1;
    endtask

    task automatic send_sym(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check_val(nm, {12'h0, lt_valid, lt_lse, at_valid, at_data, at_sop, at_eop, at_err,
                       frame_err}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of run, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        sbrx   = 1'b1;
        repeat (3) @(negedge sb_clk);
        check_outputs_zero("reset_state");
        rst = 1'b0;
        idle(4);

        // Good LT, then LT with wrong complement.
        push(EvLt, 8'h23, 1'b0, 1'b0);
        send_sym(DLE); send_sym(8'h23); send_sym(8'hDC);
        push(EvFrameErr, 8'h00, 1'b0, 1'b0);
        send_sym(DLE); send_sym(8'h23); send_sym(8'hDD);
        idle(8);
        check_val("lt_lse_held", {24'h0, lt_lse}, 32'h23);

        // Three-byte AT with eop latency check.
        push(EvAt, 8'h11, 1'b1, 1'b0);
        push(EvAt, 8'h22, 1'b0, 1'b0);
        push(EvAt, 8'h33, 1'b0, 1'b1);
        send_sym(DLE); send_sym(STX); send_sym(8'h11); send_sym(8'h22); send_sym(8'h33);
        send_sym(DLE); send_sym(ETX);
        idle(8);
        check_val("eop_latency", eop_cyc - stop_cyc, 32'd3);

        // Stuffed DLE inside payload.
        push(EvAt, 8'hFE, 1'b1, 1'b0);
        push(EvAt, 8'h01, 1'b0, 1'b1);
        send_sym(DLE); send_sym(STX); send_sym(DLE); send_sym(DLE); send_sym(8'h01);
        send_sym(DLE); send_sym(ETX);

        // Zero-length AT.
        push(EvAtErr, 8'h00, 1'b0, 1'b0);
        send_sym(DLE); send_sym(STX); send_sym(DLE); send_sym(ETX);

        // Single-byte AT.
        push(EvAt, 8'h7A, 1'b1, 1'b1);
        send_sym(DLE); send_sym(STX); send_sym(8'h7A); send_sym(DLE); send_sym(ETX);

        // Bad stop bit on second payload byte; remaining bytes still delivered.
        push(EvFrameErr, 8'h00, 1'b0, 1'b0);
        push(EvAt, 8'h11, 1'b1, 1'b0);
        push(EvAt, 8'h33, 1'b0, 1'b1);
        send_sym(DLE); send_sym(STX); send_sym(8'h11); send_frame(8'h22, 1'b0);
        send_sym(8'h33); send_sym(DLE); send_sym(ETX);
        idle(6);

        // Overflow: 65 payload bytes, 64 delivered without eop, then abort.
        for (int i = 0; i < 64; i++) push(EvAt, 8'hAA, (i == 0), 1'b0);
        push(EvAtErr, 8'h00, 1'b0, 1'b0);
        send_sym(DLE); send_sym(STX);
        for (int i = 0; i < 65; i++) send_sym(8'hAA);
        send_sym(DLE); send_sym(ETX);
        idle(30);
        check_val("overflow_drained", exp_q.size(), 32'd0);

        // Reset mid-AT after three payload bytes.
        push(EvAt, 8'h11, 1'b1, 1'b0);
        push(EvAt, 8'h22, 1'b0, 1'b0);
        send_sym(DLE); send_sym(STX); send_sym(8'h11); send_sym(8'h22); send_sym(8'h33);
        idle(6);
        rst = 1'b1;
        @(negedge sb_clk);
        check_outputs_zero("reset_mid_at");
        rst = 1'b0;
        idle(4);
        push(EvLt, 8'h10, 1'b0, 1'b0);
        send_sym(DLE); send_sym(8'h10); send_sym(8'hEF);
        idle(6);

        // Enable dropped mid-AT: exactly one abort.
        push(EvAt, 8'h44, 1'b1, 1'b0);
        push(EvAtErr, 8'h00, 1'b0, 1'b0);
        send_sym(DLE); send_sym(STX); send_sym(8'h44); send_sym(8'h55);
        idle(6);
        enable = 1'b0;
        idle(5);
        enable = 1'b1;
        idle(40);

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
